// File: rtl/xil_bram_arb_pkg.sv
// rtl/xil_bram_arb_pkg.sv - shared constants and helpers for the BRAM SDP arbiter
// Optional feature macro used by the bundle: XIL_BRAM_ARB_FWD_EN (same-address forwarding).
package xil_bram_arb_pkg;

  localparam int NREQ_MAX = 8;

  // Index width for n requesters, never less than one bit.
  function automatic int idw_f(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

  function automatic logic [NREQ_MAX-1:0] onehot_f(input logic [2:0] idx);
    logic [NREQ_MAX-1:0] oh;
    oh = '0;
    oh[idx] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/xil_rr_arb.sv
// rtl/xil_rr_arb.sv - round-robin arbiter: first request at or after ptr wins, ptr moves past winner
// Reset blocks any grant in the cycle it is asserted.
module xil_rr_arb
  import xil_bram_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = idw_f(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IDW-1:0]  idx_o,
  output logic            vld_o
);

  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [NREQ_MAX-1:0] oh;

  always_comb begin
    int cand;
    cand  = 0;
    vld_o = 1'b0;
    idx_o = '0;
    ptr_d = ptr_q;
    for (int i = 0; i < NREQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!vld_o && !rst_i && req_i[cand[IDW-1:0]]) begin
        vld_o = 1'b1;
        idx_o = cand[IDW-1:0];
      end
    end
    if (vld_o) ptr_d = (int'(idx_o) == NREQ - 1) ? '0 : IDW'(idx_o + 1'b1);
    oh    = onehot_f(3'(idx_o));
    gnt_o = vld_o ? oh[NREQ-1:0] : '0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

endmodule

// File: rtl/xil_bram_sdp_arb.sv
// rtl/xil_bram_sdp_arb.sv - shares one single-clock SDP BRAM among NREQ requesters
// XIL_BRAM_ARB_FWD_EN: carry write data in the tag pipe to forward same-address collisions.
module xil_bram_sdp_arb
  import xil_bram_arb_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int ADR  = 10,
  parameter int DAT  = 18,
  parameter int DEL  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NREQ-1:0]     wreq,
  input  logic [NREQ*ADR-1:0] wreq_ad,
  input  logic [NREQ*DAT-1:0] wreq_da,
  output logic [NREQ-1:0]     wgnt,
  input  logic [NREQ-1:0]     rreq,
  input  logic [NREQ*ADR-1:0] rreq_ad,
  output logic [NREQ-1:0]     rgnt,
  output logic [NREQ-1:0]     rvld,
  output logic [DAT-1:0]      rdat,
  output logic                ram_wen,
  output logic [ADR-1:0]      ram_wad,
  output logic [DAT-1:0]      ram_wda,
  output logic                ram_ren,
  output logic [ADR-1:0]      ram_rad,
  input  logic [DAT-1:0]      ram_rda
);

  localparam int IDW = idw_f(NREQ);

  typedef struct packed {
    logic           vld;
    logic [IDW-1:0] id;
`ifdef XIL_BRAM_ARB_FWD_EN
    logic           fwd;
    logic [DAT-1:0] fda;
`endif
  } tag_t;

  logic           w_vld, r_vld;
  logic [IDW-1:0] w_idx, r_idx;

  xil_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_warb (
    .clk_i (clk),
    .rst_i (rst),
    .req_i (wreq),
    .gnt_o (wgnt),
    .idx_o (w_idx),
    .vld_o (w_vld)
  );

  xil_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_rarb (
    .clk_i (clk),
    .rst_i (rst),
    .req_i (rreq),
    .gnt_o (rgnt),
    .idx_o (r_idx),
    .vld_o (r_vld)
  );

  logic           wen_q, ren_q;
  logic [ADR-1:0] wad_q, wad_d, rad_q, rad_d;
  logic [DAT-1:0] wda_q, wda_d;
  tag_t           tag_d;
  tag_t           tag_q [DEL+1];

  always_comb begin
    wad_d = wad_q;
    wda_d = wda_q;
    rad_d = rad_q;
    if (w_vld) begin
      wad_d = wreq_ad[w_idx*ADR +: ADR];
      wda_d = wreq_da[w_idx*DAT +: DAT];
    end
    if (r_vld) rad_d = rreq_ad[r_idx*ADR +: ADR];
    tag_d     = '0;
    tag_d.vld = r_vld;
    tag_d.id  = r_idx;
`ifdef XIL_BRAM_ARB_FWD_EN
    // Compare next-cycle RAM commands so the flag travels with the read it affects.
    tag_d.fwd = w_vld && r_vld && (wad_d == rad_d);
    tag_d.fda = wda_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q <= 1'b0;
      ren_q <= 1'b0;
      wad_q <= '0;
      wda_q <= '0;
      rad_q <= '0;
      for (int i = 0; i <= DEL; i++) tag_q[i] <= '0;
    end else begin
      wen_q    <= w_vld;
      ren_q    <= r_vld;
      wad_q    <= wad_d;
      wda_q    <= wda_d;
      rad_q    <= rad_d;
      tag_q[0] <= tag_d;
      for (int i = 1; i <= DEL; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign ram_wen = wen_q;
  assign ram_wad = wad_q;
  assign ram_wda = wda_q;
  assign ram_ren = ren_q;
  assign ram_rad = rad_q;

  // The last tag stage lines up with ram_rda of the read it describes.
  logic [NREQ_MAX-1:0] ret_oh;

  always_comb begin
    rvld   = '0;
    rdat   = '0;
    ret_oh = onehot_f(3'(tag_q[DEL].id));
    if (tag_q[DEL].vld) begin
      rvld = ret_oh[NREQ-1:0];
      rdat = ram_rda;
`ifdef XIL_BRAM_ARB_FWD_EN
      if (tag_q[DEL].fwd) rdat = tag_q[DEL].fda;
`endif
    end
  end

endmodule
